// File: rtl/uat_pkg.sv
// Shared types and constants for the uat_tx serial transmitter.
// Build option: define UAT_TX_PARITY_EN to add an even-parity bit to every frame.
package uat_pkg;

  localparam int   UAT_CLKS_PER_BIT = 8;
  localparam int   UAT_DATA_BITS    = 8;
  localparam logic UAT_START_BIT    = 1'b0;
  localparam logic UAT_STOP_BIT     = 1'b1;

`ifdef UAT_TX_PARITY_EN
  localparam int UAT_FRAME_BITS = 11;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uat_state_e;
`else
  localparam int UAT_FRAME_BITS = 10;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} uat_state_e;
`endif

endpackage

// File: rtl/uat_baud_cnt.sv
// Bit-time counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the last clock of each bit.
module uat_baud_cnt #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  input  logic i_clear,
  output logic o_bit_tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (r_cnt == LAST) r_cnt <= '0;
      else               r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_bit_tick = i_en && (r_cnt == LAST);

endmodule

// File: rtl/uat_tx.sv
// UART-style transmitter: start bit, 8 data bits LSB first, stop bit, with a one-word holding buffer.
// Build option: UAT_TX_PARITY_EN inserts an even-parity bit between data and stop.
//
// Producer handshake: a word on tx_data is taken on any rising edge where tx_valid && tx_ready;
// tx_ready is simply "holding buffer empty", so tx_data is ignored whenever tx_ready is low.
module uat_tx
  import uat_pkg::*;
#(
  parameter int CLKS_PER_BIT = UAT_CLKS_PER_BIT,
  parameter int DATA_BITS    = UAT_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 dOut,
  output uat_state_e           o_dbg_state
);

  localparam int BW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  uat_state_e           r_state, w_state_nxt;
  logic [DATA_BITS-1:0] r_buf, r_shift;
  logic                 r_buf_full;
  logic [BW-1:0]        r_bit_idx, w_bit_idx_nxt;
  logic                 r_dout, w_dout_nxt;
  logic                 r_done, w_done_nxt;
  logic                 w_load, w_shift, w_accept, w_bit_tick;
`ifdef UAT_TX_PARITY_EN
  logic                 r_parity;
`endif

  uat_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk        (clk),
    .reset      (reset),
    .i_en       (r_state != IDLE),
    .i_clear    (r_state == IDLE),
    .o_bit_tick (w_bit_tick)
  );

  assign w_accept = tx_valid && !r_buf_full;

  always_comb begin
    w_state_nxt   = r_state;
    w_dout_nxt    = r_dout;
    w_bit_idx_nxt = r_bit_idx;
    w_done_nxt    = 1'b0;
    w_load        = 1'b0;
    w_shift       = 1'b0;
    case (r_state)
      IDLE: begin
        w_dout_nxt = UAT_STOP_BIT;
        if (r_buf_full) begin
          w_state_nxt   = START;
          w_load        = 1'b1;
          w_dout_nxt    = UAT_START_BIT;
          w_bit_idx_nxt = '0;
        end
      end
      START: if (w_bit_tick) begin
        w_state_nxt   = DATA;
        w_dout_nxt    = r_shift[0];
        w_bit_idx_nxt = '0;
      end
      DATA: if (w_bit_tick) begin
        if (r_bit_idx == LAST_BIT) begin
`ifdef UAT_TX_PARITY_EN
          w_state_nxt = PARITY;
          w_dout_nxt  = r_parity;
`else
          w_state_nxt = STOP;
          w_dout_nxt  = UAT_STOP_BIT;
`endif
        end else begin
          w_shift       = 1'b1;
          w_dout_nxt    = r_shift[1];
          w_bit_idx_nxt = r_bit_idx + 1'b1;
        end
      end
`ifdef UAT_TX_PARITY_EN
      PARITY: if (w_bit_tick) begin
        w_state_nxt = STOP;
        w_dout_nxt  = UAT_STOP_BIT;
      end
`endif
      STOP: if (w_bit_tick) begin
        w_done_nxt = 1'b1;
        // A buffered word chains straight into the next start bit with no idle gap.
        if (r_buf_full) begin
          w_state_nxt   = START;
          w_load        = 1'b1;
          w_dout_nxt    = UAT_START_BIT;
          w_bit_idx_nxt = '0;
        end else begin
          w_state_nxt = IDLE;
          w_dout_nxt  = UAT_STOP_BIT;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_dout_nxt  = UAT_STOP_BIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_dout     <= UAT_STOP_BIT;
      r_done     <= 1'b0;
      r_bit_idx  <= '0;
      r_buf      <= '0;
      r_buf_full <= 1'b0;
      r_shift    <= '0;
`ifdef UAT_TX_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_dout    <= w_dout_nxt;
      r_done    <= w_done_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      if (w_load) begin
        r_shift <= r_buf;
`ifdef UAT_TX_PARITY_EN
        r_parity <= ^r_buf;
`endif
      end else if (w_shift) begin
        r_shift <= {1'b0, r_shift[DATA_BITS-1:1]};
      end
      // Accept needs the buffer empty and drain needs it full, so they are exclusive.
      if (w_accept) begin
        r_buf      <= tx_data;
        r_buf_full <= 1'b1;
      end else if (w_load) begin
        r_buf_full <= 1'b0;
      end
    end
  end

  assign tx_ready    = !r_buf_full;
  assign tx_busy     = (r_state != IDLE);
  assign tx_done     = r_done;
  assign dOut        = r_dout;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uat_tx.sv
// Directed self-checking bench for uat_tx; expected line levels come from a frame model below.
module tb_uat_tx;
  import uat_pkg::*;

  localparam int CPB        = 8;
  localparam int FRAME_CLKS = UAT_FRAME_BITS * CPB;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_busy, tx_done, dOut;
  uat_state_e o_dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  uat_tx dut (
    .clk         (clk),
    .reset       (reset),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .dOut        (dOut),
    .o_dbg_state (o_dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Expected line level for bit slot b of a frame carrying word w.
  function automatic logic exp_bit(input logic [7:0] w, input int b);
    if (b == 0) return 1'b0;
    if (b >= 1 && b <= 8) return w[b-1];
`ifdef UAT_TX_PARITY_EN
    if (b == 9) return ^w;
`endif
    return 1'b1;
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n_cmp++; if (dOut !== 1'b1) begin n_err++; $display("FAIL reset_dout cyc=%0d got=%b exp=1", i, dOut); end
      n_cmp++; if (tx_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready cyc=%0d got=%b exp=1", i, tx_ready); end
      n_cmp++; if (tx_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy cyc=%0d got=%b exp=0", i, tx_busy); end
      n_cmp++; if (tx_done !== 1'b0) begin n_err++; $display("FAIL reset_done cyc=%0d got=%b exp=0", i, tx_done); end
    end
    n_cmp++; if (o_dbg_state !== IDLE) begin n_err++; $display("FAIL reset_state got=%0d exp=%0d", o_dbg_state, IDLE); end
  endtask

  // Single frame: word accepted at edge N, line checked over cycles N+1 .. N+FRAME_CLKS+3.
  task automatic test_single(input logic [7:0] w, input string tag);
    @(negedge clk);
    tx_valid = 1'b1; tx_data = w;
    @(negedge clk);
    tx_valid = 1'b0; tx_data = 8'hEE;
    n_cmp++; if (dOut !== 1'b1) begin n_err++; $display("FAIL %s_pre_dout got=%b exp=1", tag, dOut); end
    n_cmp++; if (tx_ready !== 1'b0) begin n_err++; $display("FAIL %s_pre_ready got=%b exp=0", tag, tx_ready); end
    for (int t = 0; t < FRAME_CLKS; t++) begin
      @(negedge clk);
      n_cmp++; if (dOut !== exp_bit(w, t / CPB)) begin n_err++; $display("FAIL %s_dout t=%0d got=%b exp=%b", tag, t, dOut, exp_bit(w, t / CPB)); end
      n_cmp++; if (tx_busy !== 1'b1) begin n_err++; $display("FAIL %s_busy t=%0d got=%b exp=1", tag, t, tx_busy); end
      n_cmp++; if (tx_done !== 1'b0) begin n_err++; $display("FAIL %s_done_early t=%0d got=%b exp=0", tag, t, tx_done); end
      n_cmp++; if (tx_ready !== 1'b1) begin n_err++; $display("FAIL %s_ready t=%0d got=%b exp=1", tag, t, tx_ready); end
    end
    @(negedge clk);
    n_cmp++; if (tx_done !== 1'b1) begin n_err++; $display("FAIL %s_done_pulse got=%b exp=1", tag, tx_done); end
    n_cmp++; if (tx_busy !== 1'b0) begin n_err++; $display("FAIL %s_busy_end got=%b exp=0", tag, tx_busy); end
    n_cmp++; if (dOut !== 1'b1) begin n_err++; $display("FAIL %s_idle_dout got=%b exp=1", tag, dOut); end
    @(negedge clk);
    n_cmp++; if (tx_done !== 1'b0) begin n_err++; $display("FAIL %s_done_width got=%b exp=0", tag, tx_done); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w;
    @(negedge clk);
    tx_valid = 1'b1; tx_data = 8'h3C;
    @(negedge clk);
    n_cmp++; if (tx_ready !== 1'b0) begin n_err++; $display("FAIL b2b_ready_full got=%b exp=0", tx_ready); end
    tx_data = 8'hC3;
    for (int t = 0; t < 2 * FRAME_CLKS; t++) begin
      @(negedge clk);
      w = (t < FRAME_CLKS) ? 8'h3C : 8'hC3;
      n_cmp++; if (dOut !== exp_bit(w, (t % FRAME_CLKS) / CPB)) begin n_err++; $display("FAIL b2b_dout t=%0d got=%b exp=%b", t, dOut, exp_bit(w, (t % FRAME_CLKS) / CPB)); end
      n_cmp++; if (tx_busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy t=%0d got=%b exp=1", t, tx_busy); end
      n_cmp++; if (tx_ready !== ((t == 0 || t >= FRAME_CLKS) ? 1'b1 : 1'b0)) begin n_err++; $display("FAIL b2b_ready t=%0d got=%b", t, tx_ready); end
      n_cmp++; if (tx_done !== ((t == FRAME_CLKS) ? 1'b1 : 1'b0)) begin n_err++; $display("FAIL b2b_done t=%0d got=%b", t, tx_done); end
      if (t == 0) begin
        n_cmp++; if (o_dbg_state !== START) begin n_err++; $display("FAIL b2b_accept_in_start got=%0d exp=%0d", o_dbg_state, START); end
      end
      if (t == 1) begin tx_valid = 1'b0; tx_data = 8'h00; end
    end
    @(negedge clk);
    n_cmp++; if (tx_done !== 1'b1) begin n_err++; $display("FAIL b2b_done2 got=%b exp=1", tx_done); end
    n_cmp++; if (tx_busy !== 1'b0) begin n_err++; $display("FAIL b2b_busy_end got=%b exp=0", tx_busy); end
    repeat (2) @(negedge clk);
  endtask

  // Receiver model: finds the start edge, samples mid-bit, checks framing and data.
  task automatic test_loopback(input logic [7:0] w);
    logic [7:0] rx;
    logic       got_start;
    int         wait_cnt;
    @(negedge clk);
    tx_valid = 1'b1; tx_data = w;
    @(negedge clk);
    tx_valid = 1'b0;
    got_start = 1'b0;
    wait_cnt  = 0;
    while (!got_start && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
      if (dOut === 1'b0) got_start = 1'b1;
    end
    n_cmp++; if (!got_start) begin n_err++; $display("FAIL loop_start word=%h got=no_start exp=start_within_20", w); end
    repeat (CPB / 2 - 1) @(negedge clk);
    n_cmp++; if (dOut !== 1'b0) begin n_err++; $display("FAIL loop_startmid word=%h got=%b exp=0", w, dOut); end
    rx = 8'h00;
    for (int b = 0; b < 8; b++) begin
      repeat (CPB) @(negedge clk);
      rx[b] = dOut;
    end
`ifdef UAT_TX_PARITY_EN
    repeat (CPB) @(negedge clk);
    n_cmp++; if (dOut !== ^w) begin n_err++; $display("FAIL loop_parity word=%h got=%b exp=%b", w, dOut, ^w); end
`endif
    repeat (CPB) @(negedge clk);
    n_cmp++; if (dOut !== 1'b1) begin n_err++; $display("FAIL loop_stop word=%h got=%b exp=1", w, dOut); end
    n_cmp++; if (rx !== w) begin n_err++; $display("FAIL loop_data got=%h exp=%h", rx, w); end
    wait_cnt = 0;
    while (tx_busy === 1'b1 && wait_cnt < 2 * CPB) begin
      @(negedge clk);
      wait_cnt++;
    end
    n_cmp++; if (tx_busy !== 1'b0) begin n_err++; $display("FAIL loop_idle word=%h got=%b exp=0", w, tx_busy); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_midframe();
    @(negedge clk);
    tx_valid = 1'b1; tx_data = 8'h81;
    @(negedge clk);
    tx_data = 8'h99;
    @(negedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
    n_cmp++; if (tx_ready !== 1'b0) begin n_err++; $display("FAIL rst_mid_buffered got=%b exp=0", tx_ready); end
    repeat (27) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_cmp++; if (dOut !== 1'b1) begin n_err++; $display("FAIL rst_mid_dout got=%b exp=1", dOut); end
    n_cmp++; if (tx_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid_ready got=%b exp=1", tx_ready); end
    n_cmp++; if (tx_busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy got=%b exp=0", tx_busy); end
    for (int t = 0; t < 120; t++) begin
      @(negedge clk);
      n_cmp++; if (dOut !== 1'b1) begin n_err++; $display("FAIL rst_mid_line t=%0d got=%b exp=1", t, dOut); end
      n_cmp++; if (tx_done !== 1'b0) begin n_err++; $display("FAIL rst_mid_done t=%0d got=%b exp=0", t, tx_done); end
      n_cmp++; if (tx_busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_idle t=%0d got=%b exp=0", t, tx_busy); end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_single(8'hA5, "a5");
    test_back_to_back();
    test_loopback(8'h00);
    test_loopback(8'hFF);
    test_loopback(8'h55);
    test_loopback(8'h2A);
    test_reset_midframe();
`ifdef UAT_TX_PARITY_EN
    test_single(8'h07, "par07");
    test_single(8'h03, "par03");
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
